// File: rtl/ram_dp_arbiter.sv
// ram_dp_arbiter: round-robin arbiter sharing one dual-port synchronous RAM
// between NUM_REQ requesters. Up to two grants per cycle (one per RAM port),
// registered RAM commands, and read responses tagged with the requester ID.
// Optional build macro RAM_ARB_RDREG_EN adds a register stage on the response
// outputs (read latency T+3 instead of T+2).
module ram_dp_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2,
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic                           ram_en_0,
    output logic                           ram_en_1,
    output logic                           ram_we_0,
    output logic                           ram_we_1,
    output logic [ADDR_WIDTH-1:0]          ram_addr_0,
    output logic [ADDR_WIDTH-1:0]          ram_addr_1,
    output logic [DATA_WIDTH-1:0]          ram_wdata_0,
    output logic [DATA_WIDTH-1:0]          ram_wdata_1,
    input  logic [DATA_WIDTH-1:0]          ram_rdata_0,
    input  logic [DATA_WIDTH-1:0]          ram_rdata_1,
    output logic                           rsp_valid_0,
    output logic                           rsp_valid_1,
    output logic [ID_WIDTH-1:0]            rsp_id_0,
    output logic [ID_WIDTH-1:0]            rsp_id_1,
    output logic [DATA_WIDTH-1:0]          rsp_data_0,
    output logic [DATA_WIDTH-1:0]          rsp_data_1
);

    // RAM command as launched on one port.
    typedef struct packed {
        logic                  en;
        logic                  we;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] wdata;
    } cmd_t;

    // Read-tracking tag that travels alongside a RAM access.
    typedef struct packed {
        logic                valid;
        logic [ID_WIDTH-1:0] id;
    } tag_t;

    // Requester index reached after stepping 'ofs' places from the pointer.
    function automatic logic [ID_WIDTH-1:0] wrap_idx(input logic [ID_WIDTH-1:0] base,
                                                     input int ofs);
        return ID_WIDTH'((int'(base) + ofs) % NUM_REQ);
    endfunction

    logic [ID_WIDTH-1:0]   ptr;
    logic [ID_WIDTH-1:0]   ptr_next;
    logic                  grant_0;
    logic                  cand_1;
    logic                  grant_1;
    logic [ID_WIDTH-1:0]   idx_0;
    logic [ID_WIDTH-1:0]   idx_1;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic                  we_0;
    logic                  we_1;
    logic [DATA_WIDTH-1:0] wdata_0;
    logic [DATA_WIDTH-1:0] wdata_1;

    cmd_t                  cmd_q  [2];
    tag_t                  tag_q  [2];
    tag_t                  tag_r  [2];
    logic [DATA_WIDTH-1:0] rdata  [2];

    assign rdata[0] = ram_rdata_0;
    assign rdata[1] = ram_rdata_1;

    // Scan from the pointer upward: first valid requester is the port-0 winner,
    // the second is the port-1 candidate. Nothing is granted while in reset.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can
        // leave it unassigned and infer a latch; blocking '=' is used here.
        grant_0 = 1'b0;
        cand_1  = 1'b0;
        idx_0   = '0;
        idx_1   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (rst_n && req_valid[wrap_idx(ptr, i)]) begin
                if (!grant_0) begin
                    grant_0 = 1'b1;
                    idx_0   = wrap_idx(ptr, i);
                end else if (!cand_1) begin
                    cand_1 = 1'b1;
                    idx_1  = wrap_idx(ptr, i);
                end
            end
        end
    end

    assign addr_0  = req_addr[int'(idx_0)*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr_1  = req_addr[int'(idx_1)*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_0 = req_wdata[int'(idx_0)*DATA_WIDTH +: DATA_WIDTH];
    assign wdata_1 = req_wdata[int'(idx_1)*DATA_WIDTH +: DATA_WIDTH];
    assign we_0    = req_we[idx_0];
    assign we_1    = req_we[idx_1];

    // Port 1 stays idle when its candidate would touch the port-0 address with a write.
    assign grant_1 = cand_1 && !((addr_1 == addr_0) && (we_0 || we_1));

    // Ready is raised only for the requesters granted this cycle.
    always_comb begin
        req_ready = '0;
        if (grant_0) req_ready[idx_0] = 1'b1;
        if (grant_1) req_ready[idx_1] = 1'b1;
    end

    // Pointer moves past the last granted requester; held when nothing is granted.
    always_comb begin
        ptr_next = ptr;
        if (grant_1)      ptr_next = wrap_idx(idx_1, 1);
        else if (grant_0) ptr_next = wrap_idx(idx_0, 1);
    end

    // Register pointer, RAM commands and the two-step read tag pipeline.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            for (int p = 0; p < 2; p++) begin
                cmd_q[p] <= '0;
                tag_q[p] <= '0;
                tag_r[p] <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking '<=' so every flop
            // samples values from before this edge.
            ptr      <= ptr_next;
            cmd_q[0] <= '{en: grant_0, we: grant_0 && we_0,
                          addr: grant_0 ? addr_0 : '0, wdata: grant_0 ? wdata_0 : '0};
            cmd_q[1] <= '{en: grant_1, we: grant_1 && we_1,
                          addr: grant_1 ? addr_1 : '0, wdata: grant_1 ? wdata_1 : '0};
            tag_q[0] <= '{valid: grant_0 && !we_0, id: idx_0};
            tag_q[1] <= '{valid: grant_1 && !we_1, id: idx_1};
            tag_r[0] <= tag_q[0];
            tag_r[1] <= tag_q[1];
        end
    end

    assign ram_en_0    = cmd_q[0].en;
    assign ram_we_0    = cmd_q[0].we;
    assign ram_addr_0  = cmd_q[0].addr;
    assign ram_wdata_0 = cmd_q[0].wdata;
    assign ram_en_1    = cmd_q[1].en;
    assign ram_we_1    = cmd_q[1].we;
    assign ram_addr_1  = cmd_q[1].addr;
    assign ram_wdata_1 = cmd_q[1].wdata;

`ifdef RAM_ARB_RDREG_EN
    tag_t                  tag_o  [2];
    logic [DATA_WIDTH-1:0] data_o [2];

    // Extra response stage: capture the tag and the returned RAM data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < 2; p++) begin
                tag_o[p]  <= '0;
                data_o[p] <= '0;
            end
        end else begin
            for (int p = 0; p < 2; p++) begin
                tag_o[p]  <= tag_r[p];
                data_o[p] <= tag_r[p].valid ? rdata[p] : '0;
            end
        end
    end

    assign rsp_valid_0 = tag_o[0].valid;
    assign rsp_id_0    = tag_o[0].id;
    assign rsp_data_0  = data_o[0];
    assign rsp_valid_1 = tag_o[1].valid;
    assign rsp_id_1    = tag_o[1].id;
    assign rsp_data_1  = data_o[1];
`else
    // Read data passes straight through, masked to zero when no response is due.
    assign rsp_valid_0 = tag_r[0].valid;
    assign rsp_id_0    = tag_r[0].id;
    assign rsp_data_0  = tag_r[0].valid ? rdata[0] : '0;
    assign rsp_valid_1 = tag_r[1].valid;
    assign rsp_id_1    = tag_r[1].id;
    assign rsp_data_1  = tag_r[1].valid ? rdata[1] : '0;
`endif

endmodule

// File: tb/tb_ram_dp_arbiter.sv
// Directed bench for ram_dp_arbiter with a behavioural dual-port RAM model.
module tb_ram_dp_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int ID_WIDTH   = 2;
    localparam int ADDR_WIDTH = 8;
    localparam int DATA_WIDTH = 8;
`ifdef RAM_ARB_RDREG_EN
    localparam int RSP_EXTRA = 1;
`else
    localparam int RSP_EXTRA = 0;
`endif

    logic                          clk = 1'b0;
    logic                          rst_n = 1'b0;
    logic [NUM_REQ-1:0]            req_valid = '0;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_we = '0;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata = '0;
    logic                          ram_en_0, ram_en_1, ram_we_0, ram_we_1;
    logic [ADDR_WIDTH-1:0]         ram_addr_0, ram_addr_1;
    logic [DATA_WIDTH-1:0]         ram_wdata_0, ram_wdata_1;
    logic [DATA_WIDTH-1:0]         ram_rdata_0 = '0;
    logic [DATA_WIDTH-1:0]         ram_rdata_1 = '0;
    logic                          rsp_valid_0, rsp_valid_1;
    logic [ID_WIDTH-1:0]           rsp_id_0, rsp_id_1;
    logic [DATA_WIDTH-1:0]         rsp_data_0, rsp_data_1;

    int checks = 0;
    int errors = 0;

    logic [DATA_WIDTH-1:0] mem [256];

    ram_dp_arbiter #(
        .NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .ram_en_0(ram_en_0), .ram_en_1(ram_en_1),
        .ram_we_0(ram_we_0), .ram_we_1(ram_we_1),
        .ram_addr_0(ram_addr_0), .ram_addr_1(ram_addr_1),
        .ram_wdata_0(ram_wdata_0), .ram_wdata_1(ram_wdata_1),
        .ram_rdata_0(ram_rdata_0), .ram_rdata_1(ram_rdata_1),
        .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
        .rsp_id_0(rsp_id_0), .rsp_id_1(rsp_id_1),
        .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1)
    );

    always #5 clk = ~clk;

    // Dual-port synchronous RAM: write or read on each enabled port at the edge.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] <= '0;
        mem[8'h10] <= 8'hA5;
    end

    always @(posedge clk) begin
        if (ram_en_0) begin
            if (ram_we_0) mem[ram_addr_0] <= ram_wdata_0;
            else          ram_rdata_0 <= mem[ram_addr_0];
        end
        if (ram_en_1) begin
            if (ram_we_1) mem[ram_addr_1] <= ram_wdata_1;
            else          ram_rdata_1 <= mem[ram_addr_1];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic [7:0] addr,
                           input logic [7:0] data);
        req_valid[i]          = 1'b1;
        req_we[i]             = we;
        req_addr[i*8 +: 8]    = addr;
        req_wdata[i*8 +: 8]   = data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rsp_wait();
        step();
        repeat (RSP_EXTRA) step();
    endtask

    initial begin
        // Reset: ready must stay low even with every requester valid.
        req_valid = 4'b1111;
        #3;
        check("rst_ready", 32'(req_ready), 32'h0);
        check("rst_ram_en", 32'({ram_en_0, ram_en_1, ram_we_0, ram_we_1}), 32'h0);
        check("rst_ram_addr", 32'({ram_addr_0, ram_addr_1}), 32'h0);
        check("rst_rsp", 32'({rsp_valid_0, rsp_valid_1, rsp_data_0, rsp_data_1}), 32'h0);
        step();
        req_valid = '0;
        rst_n = 1'b1;

        // Single read: req 2 reads 0x10 (holds 0xA5).
        step();
        set_req(2, 1'b0, 8'h10, 8'h00);
        #1 check("single_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid = '0;
        check("single_cmd", 32'({ram_en_0, ram_we_0, ram_addr_0, ram_en_1}), {22'd0, 1'b1, 1'b0, 8'h10, 1'b0});
        rsp_wait();
        check("single_rsp", 32'({rsp_valid_0, rsp_id_0, rsp_data_0, rsp_valid_1}), {20'd0, 1'b1, 2'd2, 8'hA5, 1'b0});
        step();
        check("single_rsp_end", 32'(rsp_valid_0), 32'h0);

        // Wrap: pointer 3, reqs 3 and 0 write.
        set_req(3, 1'b1, 8'h30, 8'h33);
        set_req(0, 1'b1, 8'h31, 8'h44);
        #1 check("wrap_ready", 32'(req_ready), 32'b1001);
        step();
        req_valid = '0;
        check("wrap_cmd0", 32'({ram_en_0, ram_we_0, ram_addr_0, ram_wdata_0}), {14'd0, 2'b11, 8'h30, 8'h33});
        check("wrap_cmd1", 32'({ram_en_1, ram_we_1, ram_addr_1, ram_wdata_1}), {14'd0, 2'b11, 8'h31, 8'h44});
        // Pointer now 1: req 1 wins port 0 ahead of req 0.
        set_req(1, 1'b0, 8'h31, 8'h00);
        set_req(0, 1'b0, 8'h30, 8'h00);
        #1 check("ptr1_ready", 32'(req_ready), 32'b0011);
        step();
        req_valid = '0;
        check("ptr1_cmd", 32'({ram_we_0, ram_addr_0, ram_en_1, ram_we_1, ram_addr_1}), {13'd0, 1'b0, 8'h31, 1'b1, 1'b0, 8'h30});
        rsp_wait();
        check("ptr1_rsp0", 32'({rsp_valid_0, rsp_id_0, rsp_data_0}), {21'd0, 1'b1, 2'd1, 8'h44});
        check("ptr1_rsp1", 32'({rsp_valid_1, rsp_id_1, rsp_data_1}), {21'd0, 1'b1, 2'd0, 8'h33});

        // Pointer 1 -> single write from req 3 brings it to 0.
        set_req(3, 1'b1, 8'h50, 8'h55);
        #1 check("solo3_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;

        // Dual grant from pointer 0.
        set_req(0, 1'b1, 8'h01, 8'h11);
        set_req(1, 1'b1, 8'h02, 8'h22);
        #1 check("dual_ready", 32'(req_ready), 32'b0011);
        step();
        req_valid = '0;
        check("dual_cmd", 32'({ram_we_0, ram_addr_0, ram_we_1, ram_addr_1}), {14'd0, 1'b1, 8'h01, 1'b1, 8'h02});
        // Pointer now 2: req 2 wins port 0 ahead of req 0.
        set_req(0, 1'b0, 8'h01, 8'h00);
        set_req(2, 1'b0, 8'h02, 8'h00);
        #1 check("ptr2_ready", 32'(req_ready), 32'b0101);
        step();
        req_valid = '0;
        check("ptr2_cmd", 32'({ram_addr_0, ram_addr_1}), {16'd0, 8'h02, 8'h01});
        rsp_wait();
        check("ptr2_rsp", 32'({rsp_valid_0, rsp_id_0, rsp_data_0, rsp_valid_1, rsp_id_1, rsp_data_1}),
              {10'd0, 1'b1, 2'd2, 8'h22, 1'b1, 2'd0, 8'h11});

        // Pointer 1 -> 0 via a lone req 3 write.
        set_req(3, 1'b1, 8'h51, 8'h56);
        #1 check("solo3b_ready", 32'(req_ready), 32'b1000);
        step();
        req_valid = '0;

        // Conflict: req 0 writes 0x20, req 1 reads 0x20.
        set_req(0, 1'b1, 8'h20, 8'h5A);
        set_req(1, 1'b0, 8'h20, 8'h00);
        #1 check("conf_ready", 32'(req_ready), 32'b0001);
        step();
        req_valid[0] = 1'b0;
        check("conf_cmd", 32'({ram_en_0, ram_we_0, ram_addr_0, ram_wdata_0, ram_en_1}), {15'd0, 2'b11, 8'h20, 8'h5A, 1'b0});
        #1 check("conf_retry_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        check("conf_rd_cmd", 32'({ram_en_0, ram_we_0, ram_addr_0}), {22'd0, 2'b10, 8'h20});
        rsp_wait();
        check("conf_rsp", 32'({rsp_valid_0, rsp_id_0, rsp_data_0, rsp_valid_1}), {20'd0, 1'b1, 2'd1, 8'h5A, 1'b0});

        // No third candidate: pointer 2, req 2 write 0x40 blocks req 0 read 0x40; req 1 not scanned.
        set_req(2, 1'b1, 8'h40, 8'h77);
        set_req(0, 1'b0, 8'h40, 8'h00);
        set_req(1, 1'b0, 8'h41, 8'h00);
        #1 check("nothird_ready", 32'(req_ready), 32'b0100);
        step();
        req_valid[2] = 1'b0;
        check("nothird_port1_idle", 32'(ram_en_1), 32'h0);
        #1 check("nothird_next_ready", 32'(req_ready), 32'b0011);
        step();
        req_valid = '0;
        check("nothird_cmd", 32'({ram_addr_0, ram_addr_1}), {16'd0, 8'h40, 8'h41});
        rsp_wait();
        check("nothird_rsp", 32'({rsp_valid_0, rsp_id_0, rsp_data_0, rsp_valid_1, rsp_id_1, rsp_data_1}),
              {10'd0, 1'b1, 2'd0, 8'h77, 1'b1, 2'd1, 8'h00});

        // Fairness: all four valid from pointer 2 -> {2,3},{0,1},{2,3},{0,1}.
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(8'h60 + i), 8'(i));
        for (int k = 0; k < 4; k++) begin
            #1 check($sformatf("fair_ready_%0d", k), 32'(req_ready), (k % 2 == 0) ? 32'b1100 : 32'b0011);
            step();
        end
        req_valid = '0;

        // Reset mid-read: read from req 1 accepted, reset in the following cycle.
        step();
        set_req(1, 1'b0, 8'h10, 8'h00);
        #1 check("midrst_ready", 32'(req_ready), 32'b0010);
        step();
        req_valid = '0;
        rst_n = 1'b0;
        set_req(0, 1'b0, 8'h10, 8'h00);
        #1 check("midrst_ram", 32'({ram_en_0, ram_we_0, ram_addr_0, ram_en_1, ram_we_1, ram_addr_1}), 32'h0);
        check("midrst_ready_low", 32'(req_ready), 32'h0);
        step();
        req_valid = '0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("midrst_no_rsp_%0d", k), 32'({rsp_valid_0, rsp_valid_1}), 32'h0);
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
